note_recorder: RTL

Captures what the player performs on the 7 piano keys in free mode and stores it as a sequence of note events (note code, octave, duration in ticks) in an on-chip song buffer. It is the writer end of the song-data path: the auto-play/learn logic reads the recorded song back through a registered read port in the same entry format used for built-in songs. It sits beside the controller, fed by the same `keys`, `octave` and `write_on` switches.

---
 rtl/piano_pkg.sv | 49 ++++
 rtl/tick_gen.sv | 37 +++
 rtl/note_recorder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - note codes, octave encoding and song entry layout shared by recorder and song ROM
package piano_pkg;

    localparam int NOTE_W     = 4;
    localparam int OCT_W      = 2;
    localparam int SONG_DUR_W = 6;

    localparam int DUR_LSB  = 0;
    localparam int OCT_LSB  = DUR_LSB + SONG_DUR_W;
    localparam int NOTE_LSB = OCT_LSB + OCT_W;
    localparam int ENTRY_W  = NOTE_LSB + NOTE_W;

    typedef enum logic [NOTE_W-1:0] {
        NOTE_REST = 4'd0,
        NOTE_DO   = 4'd1,
        NOTE_RE   = 4'd2,
        NOTE_MI   = 4'd3,
        NOTE_FA   = 4'd4,
        NOTE_SOL  = 4'd5,
        NOTE_LA   = 4'd6,
        NOTE_SI   = 4'd7
    } note_e;

    typedef enum logic [OCT_W-1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2,
        OCT_TOP  = 2'd3
    } octave_e;

    typedef struct packed {
        logic [NOTE_W-1:0]     note;
        logic [OCT_W-1:0]      octave;
        logic [SONG_DUR_W-1:0] dur;
    } song_entry_t;

    // Lowest pressed key wins; no key pressed encodes as a rest.
    function automatic logic [NOTE_W-1:0] encode_note(input logic [6:0] k);
        logic [NOTE_W-1:0] code;
        code = NOTE_REST;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) begin
                code = NOTE_W'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-cycle tick pulse every TICK_DIV enabled cycles, restartable by clear
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - records free-play key events into a song buffer read back by auto-play/learn
module note_recorder
    import piano_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int DEPTH    = 64,
    parameter int DUR_W    = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [6:0]                        keys,
    input  logic [1:0]                        octave,
    input  logic                              write_on,
    input  logic [$clog2(DEPTH)-1:0]          rd_addr,
    output logic [NOTE_W+OCT_W+DUR_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]            song_len,
    output logic                              recording,
    output logic                              full
);

    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int LEN_W    = ADDR_W + 1;
    localparam int E_W      = NOTE_W + OCT_W + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [6:0]        keys_meta_q, keys_meta_d, keys_sync_q, keys_sync_d;
    logic              wr_meta_q, wr_meta_d, wr_sync_q, wr_sync_d, wr_prev_q, wr_prev_d;
    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  song_len_q, song_len_d;
    logic              full_q, full_d;
    logic              open_valid_q, open_valid_d;
    logic [NOTE_W-1:0] open_note_q, open_note_d;
    logic [OCT_W-1:0]  open_oct_q, open_oct_d;
    logic [DUR_W-1:0]  open_dur_q, open_dur_d;
    logic [E_W-1:0]    rd_data_q, rd_data_d;

    logic [E_W-1:0]    mem [DEPTH];
    logic              mem_we;
    logic [E_W-1:0]    mem_wdata;
    logic              commit;

    logic              wr_rise, wr_fall, is_rec, enter_rec, tick;
    logic [NOTE_W-1:0] sample_note;
    logic              sample_same;

    assign wr_rise     = wr_sync_q & ~wr_prev_q;
    assign wr_fall     = ~wr_sync_q & wr_prev_q;
    assign is_rec      = (state_q == ST_REC);
    assign enter_rec   = wr_rise && !is_rec;
    assign sample_note = encode_note(keys_sync_q);
    assign sample_same = (sample_note == open_note_q) && (octave == open_oct_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (enter_rec),
        .enable (is_rec),
        .tick   (tick)
    );

    always_comb begin
        keys_meta_d  = keys;
        keys_sync_d  = keys_meta_q;
        wr_meta_d    = write_on;
        wr_sync_d    = wr_meta_q;
        wr_prev_d    = wr_sync_q;
        rd_data_d    = mem[rd_addr];

        state_d      = state_q;
        song_len_d   = song_len_q;
        full_d       = full_q;
        open_valid_d = open_valid_q;
        open_note_d  = open_note_q;
        open_oct_d   = open_oct_q;
        open_dur_d   = open_dur_q;
        commit       = 1'b0;

        case (state_q)
            ST_REC: begin
                // The stop edge wins over a tick landing in the same cycle.
                if (wr_fall) begin
                    state_d      = ST_DONE;
                    commit       = open_valid_q && (open_note_q != NOTE_REST);
                    open_valid_d = 1'b0;
                end else if (tick) begin
                    if (!open_valid_q) begin
                        if (sample_note != NOTE_REST) begin
                            open_valid_d = 1'b1;
                            open_note_d  = sample_note;
                            open_oct_d   = octave;
                            open_dur_d   = DUR_ONE;
                        end
                    end else if (sample_same && open_dur_q != DUR_MAX) begin
                        open_dur_d = open_dur_q + 1'b1;
                    end else begin
                        commit      = 1'b1;
                        open_note_d = sample_note;
                        open_oct_d  = octave;
                        open_dur_d  = DUR_ONE;
                    end
                end
            end
            default: begin
                if (wr_rise) begin
                    state_d      = ST_REC;
                    song_len_d   = '0;
                    full_d       = 1'b0;
                    open_valid_d = 1'b0;
                    open_dur_d   = '0;
                end
            end
        endcase

        if (commit) begin
            song_len_d = song_len_q + 1'b1;
            if (song_len_q == LEN_LAST) begin
                full_d       = 1'b1;
                state_d      = ST_DONE;
                open_valid_d = 1'b0;
            end
        end
    end

    assign mem_we    = commit;
    assign mem_wdata = {open_note_q, open_oct_q, open_dur_q};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[song_len_q[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_meta_q  <= '0;
            keys_sync_q  <= '0;
            wr_meta_q    <= 1'b0;
            wr_sync_q    <= 1'b0;
            wr_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            song_len_q   <= '0;
            full_q       <= 1'b0;
            open_valid_q <= 1'b0;
            open_note_q  <= '0;
            open_oct_q   <= '0;
            open_dur_q   <= '0;
            rd_data_q    <= '0;
        end else begin
            keys_meta_q  <= keys_meta_d;
            keys_sync_q  <= keys_sync_d;
            wr_meta_q    <= wr_meta_d;
            wr_sync_q    <= wr_sync_d;
            wr_prev_q    <= wr_prev_d;
            state_q      <= state_d;
            song_len_q   <= song_len_d;
            full_q       <= full_d;
            open_valid_q <= open_valid_d;
            open_note_q  <= open_note_d;
            open_oct_q   <= open_oct_d;
            open_dur_q   <= open_dur_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign song_len  = song_len_q;
    assign recording = is_rec;
    assign full      = full_q;

endmodule
